// File: rtl/controller_led_blink_pio_if.sv
// Avalon-MM slave bus bundle for the LED blink PIO; the master drives the
// select/write strobes and the slave returns combinational read data.
interface controller_led_blink_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/controller_led_blink_pio.sv
// LED PIO with set/clear/toggle writes and a shared hardware blink generator.
// Reads are combinational, writes land on the sampling edge, out_port one edge later; never stalls.
module controller_led_blink_pio #(
    parameter int          WIDTH       = 4,
    parameter int          PERIOD_W    = 24,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    controller_led_blink_pio_if.slave   bus,
    output logic [WIDTH-1:0]            o_out_port
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_BLINK_EN = 3'd1;
    localparam logic [2:0] A_PERIOD   = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_TOGGLE   = 3'd6;

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blink_en;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;
    logic [WIDTH-1:0]    r_out;

    logic                w_wr;
    logic [WIDTH-1:0]    w_wd;
    logic [PERIOD_W-1:0] w_wp;
    logic                w_unused;

    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_wd     = bus.writedata[WIDTH-1:0];
    assign w_wp     = bus.writedata[PERIOD_W-1:0];
    assign w_unused = ^bus.writedata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data     <= RESET_VALUE[WIDTH-1:0];
            r_blink_en <= '0;
        end else if (w_wr) begin
            case (bus.address)
                A_DATA:     r_data     <= w_wd;
                A_BLINK_EN: r_blink_en <= w_wd;
                A_OUTSET:   r_data     <= r_data | w_wd;
                A_OUTCLEAR: r_data     <= r_data & ~w_wd;
                A_TOGGLE:   r_data     <= r_data ^ w_wd;
                default:    ;
            endcase
        end
    end

    // A PERIOD write outranks counter expiry and restarts in the on-phase.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (w_wr && bus.address == A_PERIOD) begin
            r_period <= w_wp;
            r_cnt    <= (w_wp == '0) ? '0 : w_wp - PERIOD_W'(1);
            r_phase  <= 1'b1;
        end else if (r_period == '0) begin
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_period - PERIOD_W'(1);
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt - PERIOD_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out <= RESET_VALUE[WIDTH-1:0];
        end else begin
            r_out <= r_data & (~r_blink_en | {WIDTH{r_phase}});
        end
    end

    assign o_out_port = r_out;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            A_DATA:     bus.readdata[WIDTH-1:0]    = r_data;
            A_BLINK_EN: bus.readdata[WIDTH-1:0]    = r_blink_en;
            A_PERIOD:   bus.readdata[PERIOD_W-1:0] = r_period;
            A_STATUS:   bus.readdata[WIDTH-1:0]    = r_out;
            default:    bus.readdata               = '0;
        endcase
    end

endmodule

// File: tb/tb_controller_led_blink_pio.sv
// Directed bench for the LED blink PIO: register map, set/clear/toggle, blink timing, async reset.
module tb_controller_led_blink_pio;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out_port;
    int         n_chk = 0;
    int         n_bad = 0;

    controller_led_blink_pio_if bus_if ();

    controller_led_blink_pio #(
        .WIDTH       (4),
        .PERIOD_W    (24),
        .RESET_VALUE (32'hA)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .bus        (bus_if),
        .o_out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle write; returns at the falling edge after the sampling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus_if.address = a;
        #1;
        chk(tag, bus_if.readdata, exp);
    endtask

    task automatic out_seq(input string tag, input logic [3:0] exp [], input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, k), {28'd0, out_port}, {28'd0, exp[k]});
        end
    endtask

    logic [3:0] exp_blink4 [];
    logic [3:0] exp_p1 [];
    logic [3:0] exp_p0 [];
    logic [3:0] exp_coll [];
    logic [3:0] exp_steady [];

    initial begin
        exp_blink4 = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hC, 4'hC, 4'hC, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_p1     = '{4'hF, 4'hC, 4'hF, 4'hC};
        exp_p0     = '{4'hF, 4'hF, 4'hF};
        exp_coll   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
        exp_steady = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};

        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        // Reset state and readback while held in reset
        #12;
        chk("rst_out", {28'd0, out_port}, 32'hA);
        rd("rst_data", 3'd0, 32'hA);
        rd("rst_blink", 3'd1, 32'h0);
        rd("rst_period", 3'd2, 32'h0);
        rd("rst_status", 3'd3, 32'hA);
        rd("rst_rsvd", 3'd7, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // DATA write: register immediately, STATUS one cycle behind
        wr(3'd0, 32'h5);
        rd("data_rd", 3'd0, 32'h5);
        rd("status_lag", 3'd3, 32'hA);
        @(negedge clk);
        rd("status_upd", 3'd3, 32'h5);

        // Set / clear / toggle
        wr(3'd0, 32'h3);
        wr(3'd4, 32'h8);
        rd("outset", 3'd0, 32'hB);
        rd("outset_rd0", 3'd4, 32'h0);
        wr(3'd5, 32'h1);
        rd("outclr", 3'd0, 32'hA);
        wr(3'd6, 32'hF);
        rd("toggle", 3'd0, 32'h5);
        wr(3'd4, 32'hFFFF_FFF0);
        rd("outset_hi", 3'd0, 32'h5);
        wr(3'd5, 32'hFFFF_FFF0);
        rd("outclr_hi", 3'd0, 32'h5);
        wr(3'd6, 32'hFFFF_FFF0);
        rd("toggle_hi", 3'd0, 32'h5);
        wr(3'd3, 32'hF);
        rd("status_wr_ign", 3'd0, 32'h5);
        wr(3'd7, 32'hF);
        rd("rsvd_wr_ign", 3'd7, 32'h0);
        rd("rsvd_wr_data", 3'd0, 32'h5);

        // Blink at PERIOD=4 on channels 1:0
        wr(3'd0, 32'hF);
        wr(3'd1, 32'h3);
        rd("blink_en_rd", 3'd1, 32'h3);
        wr(3'd2, 32'h4);
        rd("period_rd", 3'd2, 32'h4);
        out_seq("blink4", exp_blink4, 12);

        // PERIOD=1 toggles every cycle
        wr(3'd2, 32'h1);
        out_seq("period1", exp_p1, 4);

        // PERIOD=0 halts with phase on
        wr(3'd2, 32'h0);
        out_seq("period0", exp_p0, 3);

        // PERIOD=5 written on the edge where the PERIOD=3 counter expires
        wr(3'd2, 32'h3);
        @(negedge clk);
        wr(3'd2, 32'h5);
        chk("coll_now", {28'd0, out_port}, 32'hF);
        rd("coll_period", 3'd2, 32'h5);
        out_seq("coll", exp_coll, 6);

        // Async reset in the off-phase
        wr(3'd2, 32'h2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("off_phase", {28'd0, out_port}, 32'hC);
        #2 reset = 1'b1;
        #1;
        chk("arst_out", {28'd0, out_port}, 32'hA);
        @(negedge clk);
        reset = 1'b0;
        rd("arst_period", 3'd2, 32'h0);
        rd("arst_data", 3'd0, 32'hA);
        rd("arst_blink", 3'd1, 32'h0);
        wr(3'd1, 32'hF);
        out_seq("arst_steady", exp_steady, 6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/controller_led_blink_pio.md
# controller_led_blink_pio

Avalon-MM slave output port that drives WIDTH LED channels. It extends the set/clear output-register style with a toggle register and a per-channel hardware blink generator, so software sets a blink rate once and needs no further bus traffic. It sits on the controller's system interconnect beside the other PIO slaves, and `out_port` goes straight to the board LED pins.

## Interface
Parameters:
- `WIDTH`, default 4: number of output channels, legal range 1..32.
- `PERIOD_W`, default 24: width of the blink period register and counter, legal range 1..32.
- `RESET_VALUE`, default 0: reset value of the DATA register. Uses the low WIDTH bits.

Ports:
- `clk`  in  1: system clock. All state is on the rising edge.
- `reset`  in  1: asynchronous reset, active-high.
- `address`  in  3: register select (word address).
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data. Bits above WIDTH (or above PERIOD_W for PERIOD) are ignored.
- `readdata`  out  32: read data. Zero-extended, combinational.
- `out_port`  out  WIDTH: registered LED drive.

## Operation
- A write occurs when `chipselect && !write_n`.
- Register map:
  - 0 DATA: read/write. A write replaces DATA.
  - 1 BLINK_EN: read/write. A write replaces the per-channel blink enable mask.
  - 2 PERIOD: read/write. Blink half-period in clk cycles, PERIOD_W bits.
  - 3 STATUS: read-only; returns the current `out_port`. Writes are ignored.
  - 4 OUTSET: write-only. DATA <= DATA | wd.
  - 5 OUTCLEAR: write-only. DATA <= DATA & ~wd.
  - 6 TOGGLE: write-only. DATA <= DATA ^ wd.
  - 7 reserved. Reads return 0; writes are ignored.
  - Reads of addresses 4-7 return 0.
- Blink generator:
  - Uses a down-counter `cnt` (PERIOD_W bits) and a `phase` bit.
  - If PERIOD == 0, the generator is halted: `cnt` holds at 0 and `phase` is forced to 1.
  - If PERIOD != 0: when `cnt` == 0, `phase` toggles and `cnt` reloads to PERIOD-1. Otherwise `cnt` decrements. The result is that `phase` toggles every PERIOD cycles.
  - A write to PERIOD sets `cnt` to (new PERIOD)-1, or 0 if the new value is 0, and sets `phase` to 1. This restarts the pattern in the on-phase.
- Output function, registered: out_port[i] <= DATA[i] & (~BLINK_EN[i] | phase).
- Channels with BLINK_EN=0 are steady. Channels with DATA=0 are always off, whatever BLINK_EN says.
- All blinking channels share `phase`, so they blink in lockstep.

## Timing
- Reset values: DATA = RESET_VALUE, BLINK_EN = 0, PERIOD = 0, `cnt` = 0, `phase` = 1, `out_port` = RESET_VALUE[WIDTH-1:0], `readdata` = 0 for non-register addresses.
- Read latency is 0 cycles. `readdata` is valid in the same cycle as `address`, independent of `chipselect`.
- Register write latency: register state updates at the clock edge that samples the write. `out_port` reflects it one cycle later.
- Reading STATUS returns the `out_port` register as it is, i.e. one cycle behind DATA.
- Same-cycle PERIOD write and counter expiry: the write wins. No toggle happens, and `cnt`/`phase` take the restart values.
- DATA or BLINK_EN writes never disturb `cnt` or `phase`.
- Counter wrap: on reload, `cnt` = PERIOD-1. PERIOD = 1 toggles `phase` every cycle. PERIOD = 2^PERIOD_W-1 is the maximum half-period.
- Reset asserted mid-blink: all state returns to reset values immediately, without waiting for a clock. Blinking resumes only after software rewrites PERIOD.
- A single write touches exactly one register. There are no other simultaneous-write cases.

## Test plan
- Reset/readback: release reset (RESET_VALUE=4'b1010) -> `out_port`=4'b1010 and DATA reads 0xA. Write DATA=0x5, then read addresses 0 and 3 on consecutive cycles -> 0x5, then STATUS=0x5 one cycle after the write.
- Set/clear/toggle: DATA=0x3; OUTSET 0x8 -> 0xB; OUTCLEAR 0x1 -> 0xA; TOGGLE 0xF -> 0x5. Writes of 0xFFFFFFF0 to any of these leave DATA unchanged.
- Blink: DATA=0xF, BLINK_EN=0x3, PERIOD=4 -> `out_port` low bits alternate 0xF/0xC every 4 cycles with a 50% duty cycle. Bits [3:2] stay 1 throughout.
- PERIOD edge cases: PERIOD=1 -> blinking bits toggle every cycle. PERIOD=0 while blinking -> `out_port`=DATA steadily from the next cycle.
- Restart collision: PERIOD=3; write PERIOD=5 on the exact cycle `cnt` hits 0 -> no toggle that cycle, `phase`=1, and the next toggle comes 5 cycles later.
- Async reset: assert `reset` mid-off-phase between clock edges -> `out_port`=RESET_VALUE immediately. After release, PERIOD reads 0 and no blinking occurs.
